// File: rtl/wfq_pkg.sv
// -----------------------------------------------------------------------------
// wfq_pkg
// Shared definitions for the WFQ weight table: the controller state encoding
// and the default geometry (queue-index width, weight width, init weight).
// No ports; imported by the interface, the bank and the top.
// -----------------------------------------------------------------------------
package wfq_pkg;

   // Controller states: INIT sweeps defaults into both banks, IDLE serves
   // host writes/commits, COPY mirrors the new active bank into the shadow.
   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_COPY = 2'd2
   } wfq_state_t;

   localparam int          PKG_QW    = 2;
   localparam int          PKG_WW    = 16;
   localparam logic [15:0] PKG_DEF_W = 16'h4000;

endpackage

// File: rtl/wfq_weight_table_if.sv
// -----------------------------------------------------------------------------
// wfq_weight_table_if
// Groups the host configuration port and the scheduler read port of the
// weight table.
//   cfg_we/cfg_addr/cfg_din : host write into the shadow bank
//   cfg_commit              : host request to swap shadow and active banks
//   cfg_ready               : host strobes are honoured only while high
//   rd_req/rd_addr          : scheduler read request
//   rd_valid/rd_dout        : read response, one cycle after the request
//   init_done               : default sweep complete
// Modports: master = host/scheduler side, slave = the table.
// -----------------------------------------------------------------------------
interface wfq_weight_table_if
   import wfq_pkg::*;
#(
   parameter int QW = PKG_QW,
   parameter int WW = PKG_WW
);

   logic          cfg_we;
   logic [QW-1:0] cfg_addr;
   logic [WW-1:0] cfg_din;
   logic          cfg_commit;
   logic          cfg_ready;
   logic          rd_req;
   logic [QW-1:0] rd_addr;
   logic          rd_valid;
   logic [WW-1:0] rd_dout;
   logic          init_done;

   modport master (
      output cfg_we, cfg_addr, cfg_din, cfg_commit, rd_req, rd_addr,
      input  cfg_ready, rd_valid, rd_dout, init_done
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_din, cfg_commit, rd_req, rd_addr,
      output cfg_ready, rd_valid, rd_dout, init_done
   );

endinterface

// File: rtl/wfq_weight_bank.sv
// -----------------------------------------------------------------------------
// wfq_weight_bank
// One 2**QW x WW weight bank: a single write port and two independent
// synchronous read ports (port 1 serves the scheduler, port 2 the bank copy).
// Each read register only updates when its enable is high, so the last read
// value is held otherwise.
//   clk              : clock
//   we/waddr/wdata   : write port
//   re1/ra1 -> q1    : read port 1 (registered)
//   re2/ra2 -> q2    : read port 2 (registered)
// -----------------------------------------------------------------------------
module wfq_weight_bank
   import wfq_pkg::*;
#(
   parameter int QW = PKG_QW,
   parameter int WW = PKG_WW
) (
   input  logic          clk,
   input  logic          we,
   input  logic [QW-1:0] waddr,
   input  logic [WW-1:0] wdata,
   input  logic          re1,
   input  logic [QW-1:0] ra1,
   output logic [WW-1:0] q1,
   input  logic          re2,
   input  logic [QW-1:0] ra2,
   output logic [WW-1:0] q2
);

   logic [WW-1:0] mem [2**QW];

   // NOTE: storage and read registers carry no reset so this maps onto RAM;
   // the table's INIT sweep is what gives the contents defined values.
   always_ff @(posedge clk) begin
      if (we)  mem[waddr] <= wdata;
      if (re1) q1 <= mem[ra1];
      if (re2) q2 <= mem[ra2];
   end

endmodule

// File: rtl/wfq_weight_table.sv
// -----------------------------------------------------------------------------
// wfq_weight_table
// Double-buffered WFQ weight table. The scheduler reads the active bank with
// one cycle of latency; the host writes the shadow bank and commits to swap.
// After a swap the new active bank is copied into the new shadow bank so the
// host always edits a full copy of what is live.
//   clk : clock (rising edge)
//   rst : synchronous, active-high reset; restarts the INIT sweep
//   bus : wfq_weight_table_if.slave (config + read ports)
// -----------------------------------------------------------------------------
module wfq_weight_table
   import wfq_pkg::*;
#(
   parameter int            QW    = PKG_QW,
   parameter int            WW    = PKG_WW,
   parameter logic [WW-1:0] DEF_W = WW'(PKG_DEF_W)
) (
   input logic                  clk,
   input logic                  rst,
   wfq_weight_table_if.slave    bus
);

   // idx is one bit wider than an address: during COPY the value 2**QW marks
   // the final cycle that only retires the last pending copy write.
   localparam logic [QW:0]   N_ENT    = {1'b1, {QW{1'b0}}};
   localparam logic [QW:0]   IDX_ONE  = (QW+1)'(1);
   localparam logic [QW-1:0] ADDR_ONE = QW'(1);

   wfq_state_t    state, state_nx;
   logic [QW:0]   idx, idx_nx;
   logic          active_sel;   // 0: bank A active, 1: bank B active
   logic          init_done_q;
   logic          rd_valid_q;
   logic          rd_zero;      // rd_dout forced to 0 until the first read after reset
   logic          rd_bank;      // bank that served the last accepted read

   logic          cfg_ready;
   logic          we_acc, commit_acc, rd_fire, cp_rd;
   logic          we_shadow, we_a, we_b;
   logic [QW-1:0] waddr;
   logic [WW-1:0] wdata;
   logic [WW-1:0] qa1, qa2, qb1, qb2;

   assign cfg_ready  = init_done_q && (state == ST_IDLE);
   assign we_acc     = bus.cfg_we && cfg_ready;
   assign commit_acc = bus.cfg_commit && cfg_ready;
   assign rd_fire    = bus.rd_req && init_done_q;
   assign cp_rd      = (state == ST_COPY) && !idx[QW];

   // NOTE: every output of a combinational block gets a default first so no
   // path leaves it unassigned and a latch is never inferred.
   always_comb begin
      state_nx  = state;
      idx_nx    = idx;
      we_shadow = 1'b0;
      we_a      = 1'b0;
      we_b      = 1'b0;
      waddr     = idx[QW-1:0];
      wdata     = DEF_W;
      case (state)
         ST_INIT: begin
            we_a   = 1'b1;
            we_b   = 1'b1;
            idx_nx = idx + IDX_ONE;
            if (idx == N_ENT - IDX_ONE) begin
               state_nx = ST_IDLE;
               idx_nx   = '0;
            end
         end
         ST_IDLE: begin
            if (we_acc) begin
               we_shadow = 1'b1;
               waddr     = bus.cfg_addr;
               wdata     = bus.cfg_din;
            end
            if (commit_acc) begin
               state_nx = ST_COPY;
               idx_nx   = '0;
            end
         end
         ST_COPY: begin
            // Port-2 data read at idx-1 lands now; write it to the shadow.
            if (idx != '0) begin
               we_shadow = 1'b1;
               waddr     = idx[QW-1:0] - ADDR_ONE;
               wdata     = active_sel ? qb2 : qa2;
            end
            idx_nx = idx + IDX_ONE;
            if (idx == N_ENT) begin
               state_nx = ST_IDLE;
               idx_nx   = '0;
            end
         end
         default: begin
            state_nx = ST_INIT;
            idx_nx   = '0;
         end
      endcase
      if (we_shadow) begin
         we_a = active_sel;
         we_b = !active_sel;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_INIT;
         idx         <= '0;
         active_sel  <= 1'b0;
         init_done_q <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_zero     <= 1'b1;
         rd_bank     <= 1'b0;
      end else begin
         state      <= state_nx;
         idx        <= idx_nx;
         rd_valid_q <= rd_fire;
         if (commit_acc)          active_sel  <= !active_sel;
         if (state == ST_IDLE)    init_done_q <= 1'b1;
         if (rd_fire) begin
            rd_zero <= 1'b0;
            rd_bank <= active_sel;
         end
      end
   end

   wfq_weight_bank #(.QW(QW), .WW(WW)) u_bank_a (
      .clk   (clk),
      .we    (we_a),
      .waddr (waddr),
      .wdata (wdata),
      .re1   (rd_fire),
      .ra1   (bus.rd_addr),
      .q1    (qa1),
      .re2   (cp_rd),
      .ra2   (idx[QW-1:0]),
      .q2    (qa2)
   );

   wfq_weight_bank #(.QW(QW), .WW(WW)) u_bank_b (
      .clk   (clk),
      .we    (we_b),
      .waddr (waddr),
      .wdata (wdata),
      .re1   (rd_fire),
      .ra1   (bus.rd_addr),
      .q1    (qb1),
      .re2   (cp_rd),
      .ra2   (idx[QW-1:0]),
      .q2    (qb2)
   );

   assign bus.cfg_ready = cfg_ready;
   assign bus.init_done = init_done_q;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.rd_dout   = rd_zero ? '0 : (rd_bank ? qb1 : qa1);

endmodule

// File: tb/tb_wfq_weight_table.sv
// -----------------------------------------------------------------------------
// tb_wfq_weight_table
// Self-checking bench for wfq_weight_table. A transaction-level model keeps
// the active and shadow contents as plain arrays, plus a cycles-since-reset
// count and a busy countdown after each commit.
// -----------------------------------------------------------------------------
module tb_wfq_weight_table;
   import wfq_pkg::*;

   localparam int QW = 2;
   localparam int WW = 16;
   localparam int N  = 2**QW;
   localparam logic [WW-1:0] DEF = 16'h4000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wfq_weight_table_if #(.QW(QW), .WW(WW)) bus ();

   wfq_weight_table #(.QW(QW), .WW(WW), .DEF_W(DEF)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [WW-1:0] m_act [N];
   logic [WW-1:0] m_shd [N];
   int            m_since = 0;
   int            m_busy  = 0;
   logic          m_valid = 1'b0;
   logic [WW-1:0] m_dout  = '0;
   logic          m_init_done = 1'b0;
   logic          m_ready     = 1'b0;

   task automatic idle_inputs();
      bus.cfg_we     = 1'b0;
      bus.cfg_addr   = '0;
      bus.cfg_din    = '0;
      bus.cfg_commit = 1'b0;
      bus.rd_req     = 1'b0;
      bus.rd_addr    = '0;
   endtask

   // Advance one clock: update the model from the inputs of the current
   // cycle, then step past the edge so outputs can be sampled.
   task automatic tick();
      logic done, rdy;
      if (rst) begin
         m_since = 0;
         m_busy  = 0;
         m_valid = 1'b0;
         m_dout  = '0;
         for (int i = 0; i < N; i++) begin
            m_act[i] = DEF;
            m_shd[i] = DEF;
         end
      end else begin
         done = (m_since >= N + 1);
         rdy  = done && (m_busy == 0);
         if (bus.rd_req && done) begin
            m_valid = 1'b1;
            m_dout  = m_act[bus.rd_addr];
         end else begin
            m_valid = 1'b0;
         end
         if (rdy && bus.cfg_we) m_shd[bus.cfg_addr] = bus.cfg_din;
         if (rdy && bus.cfg_commit) begin
            m_act  = m_shd;   // new shadow is a copy of the new active bank
            m_busy = N + 1;
         end else if (m_busy > 0) begin
            m_busy--;
         end
         if (m_since < 1000) m_since++;
      end
      @(posedge clk);
      #1;
      m_init_done = (m_since >= N + 1);
      m_ready     = m_init_done && (m_busy == 0);
   endtask

   task automatic wait_ready(input string name);
      int n = 0;
      idle_inputs();
      while (!bus.cfg_ready && n < 40) begin
         tick();
         n++;
      end
      n_tests++;
      if (bus.cfg_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s: cfg_ready=%b after %0d cycles, required 1", name, bus.cfg_ready, n);
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_tests++;
      if ({bus.rd_valid, bus.rd_dout, bus.init_done, bus.cfg_ready} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: valid=%b dout=%h init_done=%b ready=%b, required all 0",
                  bus.rd_valid, bus.rd_dout, bus.init_done, bus.cfg_ready);
      end
      for (int i = 0; i < N; i++) begin
         bus.rd_req  = 1'b1;
         bus.rd_addr = QW'(i);
         tick();
         n_tests++;
         if (bus.rd_valid !== 1'b0 || bus.init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL init_read%0d: valid=%b init_done=%b, required 0 0",
                     i, bus.rd_valid, bus.init_done);
         end
      end
      idle_inputs();
      tick();   // now in cycle 5
      n_tests++;
      if (bus.init_done !== 1'b1 || bus.cfg_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL init_done_cycle5: init_done=%b ready=%b, required 1 1",
                  bus.init_done, bus.cfg_ready);
      end
      for (int i = 0; i < N; i++) begin
         bus.rd_req  = 1'b1;
         bus.rd_addr = QW'(i);
         tick();
         n_tests++;
         if (bus.rd_valid !== 1'b1 || bus.rd_dout !== 16'h4000) begin
            n_fail++;
            $display("FAIL default_read%0d: valid=%b dout=%h, required 1 4000",
                     i, bus.rd_valid, bus.rd_dout);
         end
      end
      idle_inputs();
      tick();
      n_tests++;
      if (bus.rd_valid !== 1'b0 || bus.rd_dout !== 16'h4000) begin
         n_fail++;
         $display("FAIL read_hold: valid=%b dout=%h, required 0 4000", bus.rd_valid, bus.rd_dout);
      end
   endtask

   task automatic test_shadow_write();
      idle_inputs();
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 2'd2;
      bus.cfg_din  = 16'h1999;
      tick();
      idle_inputs();
      bus.rd_req  = 1'b1;
      bus.rd_addr = 2'd2;
      tick();
      n_tests++;
      if (bus.rd_dout !== 16'h4000) begin
         n_fail++;
         $display("FAIL shadow_isolated: dout=%h, required 4000", bus.rd_dout);
      end
      idle_inputs();
      bus.cfg_commit = 1'b1;
      tick();
      idle_inputs();
      n_tests++;
      if (bus.cfg_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL ready_after_commit: ready=%b, required 0", bus.cfg_ready);
      end
      bus.rd_req  = 1'b1;
      bus.rd_addr = 2'd2;
      tick();
      n_tests++;
      if (bus.rd_valid !== 1'b1 || bus.rd_dout !== 16'h1999) begin
         n_fail++;
         $display("FAIL commit_read: valid=%b dout=%h, required 1 1999", bus.rd_valid, bus.rd_dout);
      end
      wait_ready("shadow_write_ready");
   endtask

   task automatic test_write_commit();
      idle_inputs();
      bus.cfg_we     = 1'b1;
      bus.cfg_addr   = 2'd3;
      bus.cfg_din    = 16'h4CCC;
      bus.cfg_commit = 1'b1;
      bus.rd_req     = 1'b1;
      bus.rd_addr    = 2'd3;
      tick();
      n_tests++;
      if (bus.rd_dout !== 16'h4000) begin
         n_fail++;
         $display("FAIL same_cycle_old: dout=%h, required 4000", bus.rd_dout);
      end
      idle_inputs();
      bus.rd_req  = 1'b1;
      bus.rd_addr = 2'd3;
      tick();
      n_tests++;
      if (bus.rd_dout !== 16'h4CCC) begin
         n_fail++;
         $display("FAIL same_cycle_new: dout=%h, required 4ccc", bus.rd_dout);
      end
      wait_ready("write_commit_ready");
   endtask

   task automatic test_copy_window();
      logic [WW-1:0] want [N];
      int n = 0;
      want[0] = 16'h4000; want[1] = 16'h4000; want[2] = 16'h1999; want[3] = 16'h4CCC;
      idle_inputs();
      bus.cfg_commit = 1'b1;
      tick();
      idle_inputs();
      while (!bus.cfg_ready && n < 20) begin
         bus.cfg_we   = (n == 1);
         bus.cfg_addr = 2'd0;
         bus.cfg_din  = 16'h8000;
         tick();
         n++;
      end
      idle_inputs();
      n_tests++;
      if (n != N + 1) begin
         n_fail++;
         $display("FAIL copy_busy_len: %0d cycles, required %0d", n, N + 1);
      end
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < N; i++) begin
            bus.rd_req  = 1'b1;
            bus.rd_addr = QW'(i);
            tick();
            n_tests++;
            if (bus.rd_dout !== want[i]) begin
               n_fail++;
               $display("FAIL copy_pass%0d_idx%0d: dout=%h, required %h", pass, i, bus.rd_dout, want[i]);
            end
         end
         idle_inputs();
         if (pass == 0) begin
            bus.cfg_commit = 1'b1;
            tick();
            wait_ready("second_commit_ready");
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [WW-1:0] want;
      idle_inputs();
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 2'd3;
      bus.cfg_din  = 16'h1234;
      tick();
      idle_inputs();
      for (int k = 0; k < 12; k++) begin
         bus.rd_req     = 1'b1;
         bus.rd_addr    = 2'd3;
         bus.cfg_commit = (k == 3);
         tick();
         want = (k <= 3) ? 16'h4CCC : 16'h1234;
         n_tests++;
         if (bus.rd_valid !== 1'b1 || bus.rd_dout !== want) begin
            n_fail++;
            $display("FAIL b2b_k%0d: valid=%b dout=%h, required 1 %h", k, bus.rd_valid, bus.rd_dout, want);
         end
      end
      wait_ready("b2b_ready");
   endtask

   task automatic test_reset_in_copy();
      int n = 0;
      idle_inputs();
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 2'd1;
      bus.cfg_din  = 16'h7777;
      tick();
      idle_inputs();
      bus.cfg_commit = 1'b1;
      bus.rd_req     = 1'b1;
      tick();
      idle_inputs();
      bus.rd_req = 1'b1;
      tick();
      tick();   // now in COPY cycle 2
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle_inputs();
      n_tests++;
      if ({bus.rd_valid, bus.rd_dout, bus.init_done, bus.cfg_ready} !== '0) begin
         n_fail++;
         $display("FAIL copy_reset_outputs: valid=%b dout=%h init_done=%b ready=%b, required all 0",
                  bus.rd_valid, bus.rd_dout, bus.init_done, bus.cfg_ready);
      end
      while (!bus.init_done && n < 20) begin
         tick();
         n++;
      end
      n_tests++;
      if (n != N + 1) begin
         n_fail++;
         $display("FAIL copy_reset_init_len: %0d cycles, required %0d", n, N + 1);
      end
      for (int i = 0; i < N; i++) begin
         bus.rd_req  = 1'b1;
         bus.rd_addr = QW'(i);
         tick();
         n_tests++;
         if (bus.rd_valid !== 1'b1 || bus.rd_dout !== 16'h4000) begin
            n_fail++;
            $display("FAIL post_reset_idx%0d: valid=%b dout=%h, required 1 4000",
                     i, bus.rd_valid, bus.rd_dout);
         end
      end
      idle_inputs();
   endtask

   task automatic test_random();
      for (int c = 0; c < 800; c++) begin
         rst            = ($urandom_range(0, 199) == 0);
         bus.rd_req     = ($urandom_range(0, 3) != 0);
         bus.rd_addr    = QW'($urandom);
         bus.cfg_we     = ($urandom_range(0, 2) == 0);
         bus.cfg_addr   = QW'($urandom);
         bus.cfg_din    = WW'($urandom);
         bus.cfg_commit = ($urandom_range(0, 9) == 0);
         tick();
         n_tests++;
         if (bus.rd_valid !== m_valid || bus.rd_dout !== m_dout ||
             bus.init_done !== m_init_done || bus.cfg_ready !== m_ready) begin
            n_fail++;
            $display("FAIL random_c%0d: valid=%b dout=%h init_done=%b ready=%b, required %b %h %b %b",
                     c, bus.rd_valid, bus.rd_dout, bus.init_done, bus.cfg_ready,
                     m_valid, m_dout, m_init_done, m_ready);
         end
      end
      rst = 1'b0;
      idle_inputs();
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_shadow_write();
      test_write_commit();
      test_copy_window();
      test_back_to_back();
      test_reset_in_copy();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
